// File: rtl/gpio_uart_rx_pkg.sv
// Shared definitions for the GPIO UART receiver: FSM encoding, register
// offsets and STATUS bit layout.
package gpio_uart_rx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int REG_DATA   = 0;
  localparam int REG_STATUS = 1;

  localparam int STAT_OVR_BIT  = 7;
  localparam int STAT_FERR_BIT = 6;
  localparam int STAT_CNT_W    = 5;

endpackage

// File: rtl/gpio_uart_rx_fifo.sv
// Receive byte FIFO: power-of-two depth, wrapping pointers, separate count.
module rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/gpio_uart_rx.sv
// 8N1 serial receiver on a GPIO pin with a memory-mapped DATA/STATUS pair
// and a small receive FIFO.
module gpio_uart_rx
  import gpio_uart_rx_pkg::*;
#(
  parameter int          CLK_HZ     = 16000000,
  parameter int          BAUD       = 9600,
  parameter logic [14:0] BASE_ADDR  = 15'h6010,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] rdData,
  output logic        rdSel,
  input  logic        gpioInSig,
  output logic        rxIrq
);
  localparam int BIT_TICKS = CLK_HZ / BAUD;
  localparam int CNT_W     = $clog2(BIT_TICKS + 1);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(BIT_TICKS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(BIT_TICKS - 1);

  logic                        sync0, sync1, line_d;
  logic [1:0]                  state;
  logic [CNT_W-1:0]            cnt;
  logic [2:0]                  bit_idx;
  logic [7:0]                  shreg;
  logic                        expire, push, ferr_set, ovr_set;
  logic                        sel_data, sel_stat, pop, clr;
  logic                        ovr, ferr, full, empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [7:0]                  head;
  logic [15:0]                 status;
  logic                        unused_outm;

  assign unused_outm = ^outM;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync0  <= 1'b1;
      sync1  <= 1'b1;
      line_d <= 1'b1;
    end else begin
      sync0  <= gpioInSig;
      sync1  <= sync0;
      line_d <= sync1;
    end
  end

  assign expire = (cnt == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (line_d & ~sync1) begin
            state <= ST_START;
            cnt   <= HALF_LD;
          end
        end
        ST_START: begin
          if (!expire) cnt <= cnt - CNT_W'(1);
          else if (!sync1) begin
            state   <= ST_DATA;
            cnt     <= FULL_LD;
            bit_idx <= '0;
          end else state <= ST_IDLE;
        end
        ST_DATA: begin
          if (!expire) cnt <= cnt - CNT_W'(1);
          else begin
            shreg   <= {sync1, shreg[7:1]};
            cnt     <= FULL_LD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end
        end
        default: begin
          if (!expire) cnt <= cnt - CNT_W'(1);
          else state <= ST_IDLE;
        end
      endcase
    end
  end

  assign push     = (state == ST_STOP) & expire & sync1;
  assign ferr_set = (state == ST_STOP) & expire & ~sync1;
  assign ovr_set  = push & full & ~pop;

  assign sel_data = (addressM == BASE_ADDR + 15'(REG_DATA));
  assign sel_stat = (addressM == BASE_ADDR + 15'(REG_STATUS));
  assign rdSel    = sel_data | sel_stat;
  assign pop      = writeM & sel_data;
  assign clr      = writeM & sel_stat;

  // a flag raised in the same cycle as a clear survives
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & ~clr);
      ferr <= ferr_set | (ferr & ~clr);
    end
  end

  rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  assign rxIrq = ~empty;

  always_comb begin
    status                       = '0;
    status[STAT_OVR_BIT]         = ovr;
    status[STAT_FERR_BIT]        = ferr;
    status[STAT_CNT_W-1:0]       = STAT_CNT_W'(count);
    rdData                       = 16'h0000;
    if (sel_data && !empty) rdData = {8'h00, head};
    else if (sel_stat)      rdData = status;
  end

endmodule

// File: tb/tb_gpio_uart_rx.sv
// Directed bench for gpio_uart_rx with a queue-based register model checked
// every cycle plus literal register expectations.
module tb_gpio_uart_rx;
  localparam logic [14:0] BASE  = 15'h6010;
  localparam int          DEPTH = 4;
  localparam int          BT    = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [14:0] addressM = '0;
  logic [15:0] outM = '0;
  logic        writeM = 1'b0;
  logic [15:0] rdData;
  logic        rdSel;
  logic        gpioInSig = 1'b1;
  logic        rxIrq;

  gpio_uart_rx #(
    .CLK_HZ(160), .BAUD(10), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .addressM(addressM), .outM(outM), .writeM(writeM),
    .rdData(rdData), .rdSel(rdSel), .gpioInSig(gpioInSig), .rxIrq(rxIrq)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  // reference model: received bytes, sticky flags, and the frame outcome
  // the stimulus expects on the current edge
  logic [7:0] mq[$];
  logic       m_ovr = 1'b0, m_ferr = 1'b0;
  logic       exp_push = 1'b0, exp_err = 1'b0;
  logic [7:0] exp_byte = '0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mq.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      if (writeM && addressM == BASE && mq.size() > 0) void'(mq.pop_front());
      if (writeM && addressM == BASE + 15'd1) begin
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
      end
      if (exp_err) m_ferr = 1'b1;
      if (exp_push) begin
        if (mq.size() < DEPTH) mq.push_back(exp_byte);
        else m_ovr = 1'b1;
      end
    end
  end

  function automatic logic [15:0] model_rd(input logic [14:0] a);
    if (a == BASE)          return (mq.size() > 0) ? {8'h00, mq[0]} : 16'h0000;
    if (a == BASE + 15'd1)  return {8'h00, m_ovr, m_ferr, 1'b0, 5'(mq.size())};
    return 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_rdData", rdData, model_rd(addressM));
      chk("model_rdSel", {15'd0, rdSel},
          {15'd0, (addressM == BASE) || (addressM == BASE + 15'd1)});
      chk("model_rxIrq", {15'd0, rxIrq}, {15'd0, mq.size() > 0});
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic read_lit(input logic [14:0] a, input logic [15:0] exp, input string nm);
    step();
    addressM = a;
    @(negedge CLK);
    chk(nm, rdData, exp);
  endtask

  task automatic irq_lit(input logic exp, input string nm);
    @(negedge CLK);
    chk(nm, {15'd0, rxIrq}, {15'd0, exp});
  endtask

  task automatic bus_write(input logic [14:0] a);
    step();
    addressM = a;
    outM     = 16'($urandom);
    writeM   = 1'b1;
    step();
    writeM   = 1'b0;
  endtask

  // line driven just after an edge; the stop bit is sampled on the edge
  // 155 edges after the start bit is first driven
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pop_at_stop);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int n = 0; n < 10 * BT; n++) begin
      step();
      gpioInSig = bits[n / BT];
      if (n == 154) begin
        exp_byte = b;
        exp_push = stop_bit;
        exp_err  = ~stop_bit;
        if (pop_at_stop) begin
          addressM = BASE;
          writeM   = 1'b1;
        end
      end
      if (n == 155) begin
        exp_push = 1'b0;
        exp_err  = 1'b0;
        writeM   = 1'b0;
      end
    end
    gpioInSig = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    logic [9:0] abort_bits;
    repeat (3) step();
    RST = 1'b1;
    chk_en = 1'b1;
    read_lit(BASE + 15'd1, 16'h0000, "reset_status");
    read_lit(BASE, 16'h0000, "reset_data");
    irq_lit(1'b0, "reset_irq");

    send_frame(8'h41, 1'b1, 1'b0);
    read_lit(BASE + 15'd1, 16'h0001, "clean_status");
    read_lit(BASE, 16'h0041, "clean_data");
    irq_lit(1'b1, "clean_irq");
    read_lit(15'h6012, 16'h0000, "unselected_read");
    bus_write(BASE);
    read_lit(BASE + 15'd1, 16'h0000, "pop_status");
    irq_lit(1'b0, "pop_irq");

    step();
    gpioInSig = 1'b0;
    repeat (4) step();
    gpioInSig = 1'b1;
    repeat (30) step();
    read_lit(BASE + 15'd1, 16'h0000, "glitch_status");

    send_frame(8'h55, 1'b0, 1'b0);
    read_lit(BASE + 15'd1, 16'h0040, "ferr_status");
    bus_write(BASE + 15'd1);
    read_lit(BASE + 15'd1, 16'h0000, "ferr_cleared");

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    read_lit(BASE + 15'd1, 16'h0084, "overrun_status");
    for (int i = 1; i <= 4; i++) begin
      read_lit(BASE, 16'(i), "overrun_pop_data");
      bus_write(BASE);
    end
    read_lit(BASE, 16'h0000, "drained_data");
    bus_write(BASE + 15'd1);
    read_lit(BASE + 15'd1, 16'h0000, "overrun_cleared");

    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    read_lit(BASE + 15'd1, 16'h0004, "full_status");
    send_frame(8'hA5, 1'b1, 1'b1);
    read_lit(BASE + 15'd1, 16'h0004, "push_pop_full_status");
    read_lit(BASE, 16'h0022, "push_pop_head");
    bus_write(BASE);
    read_lit(BASE, 16'h0033, "push_pop_2");
    bus_write(BASE);
    read_lit(BASE, 16'h0044, "push_pop_3");
    bus_write(BASE);
    read_lit(BASE, 16'h00A5, "push_pop_tail");
    bus_write(BASE);
    read_lit(BASE + 15'd1, 16'h0000, "push_pop_empty");

    abort_bits = {1'b1, 8'h3C, 1'b0};
    for (int n = 0; n <= 4 * BT + 8; n++) begin
      step();
      gpioInSig = abort_bits[n / BT];
    end
    RST = 1'b0;
    gpioInSig = 1'b1;
    read_lit(BASE + 15'd1, 16'h0000, "in_reset_status");
    repeat (3) step();
    RST = 1'b1;
    repeat (20) step();
    read_lit(BASE + 15'd1, 16'h0000, "post_reset_status");
    send_frame(8'h7E, 1'b1, 1'b0);
    read_lit(BASE + 15'd1, 16'h0001, "after_abort_status");
    read_lit(BASE, 16'h007E, "after_abort_data");

    repeat (4) step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
